// File: rtl/fill_drain_sequencer.sv
// fill_drain_sequencer: drives the water valve and the drain pump for one-shot
// fill/drain commands issued by the main washing-machine FSM. It watches the
// water level, enforces per-operation timeouts, supports pause/abort and
// raises sticky flow/drainage error flags until they are cleared.
// Optional feature macro: LEVEL_DEBOUNCE_EN. When it is defined, completion
// conditions must hold for DEBOUNCE consecutive active cycles, and IDLE
// requests always pass through FILL/DRAIN.
module fill_drain_sequencer #(
    parameter int LEVEL_W       = 10,
    parameter int FILL_TIMEOUT  = 40,
    parameter int DRAIN_TIMEOUT = 30,
    parameter int EMPTY_LEVEL   = 20,
    parameter int DEBOUNCE      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fill_req,
    input  logic               drain_req,
    input  logic [LEVEL_W-1:0] target_level,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic               pause,
    input  logic               abort,
    input  logic               clear_error,
    output logic               water_valve,
    output logic               drain_pump,
    output logic               busy,
    output logic               done,
    output logic               water_flow_error,
    output logic               drainage_error
);

    localparam int TMAX    = (FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT;
    localparam int TIMER_W = $clog2(TMAX) + 1;
    localparam int DEB_W   = $clog2(DEBOUNCE + 1) + 1;
`ifdef LEVEL_DEBOUNCE_EN
    localparam int DEB_LEN     = DEBOUNCE;
    localparam bit SHORTCUT_EN = 1'b0;
`else
    localparam int DEB_LEN     = 1;
    localparam bit SHORTCUT_EN = 1'b1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_PAUSED,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t               state_reg, state_next;
    state_t               saved_reg, saved_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [LEVEL_W-1:0]   target_reg, target_next;
    logic [DEB_W-1:0]     deb_reg, deb_next;
    logic                 flow_err_reg, flow_err_next;
    logic                 drain_err_reg, drain_err_next;
    logic                 valve_reg, pump_reg, busy_reg, done_reg;

    logic level_full;
    logic level_empty;
    logic deb_met;

    assign level_full  = (water_level_sensor >= target_reg);
    assign level_empty = (water_level_sensor <= LEVEL_W'(EMPTY_LEVEL));
    assign deb_met     = (deb_reg == DEB_W'(DEB_LEN - 1));

    // State, bookkeeping and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            saved_reg     <= ST_IDLE;
            timer_reg     <= '0;
            target_reg    <= '0;
            deb_reg       <= '0;
            flow_err_reg  <= 1'b0;
            drain_err_reg <= 1'b0;
            valve_reg     <= 1'b0;
            pump_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            saved_reg     <= saved_next;
            timer_reg     <= timer_next;
            target_reg    <= target_next;
            deb_reg       <= deb_next;
            flow_err_reg  <= flow_err_next;
            drain_err_reg <= drain_err_next;
            valve_reg     <= (state_next == ST_FILL);
            pump_reg      <= (state_next == ST_DRAIN);
            busy_reg      <= (state_next == ST_FILL) || (state_next == ST_DRAIN) ||
                             (state_next == ST_PAUSED);
            done_reg      <= (state_next == ST_DONE);
        end
    end

    // Next-state logic; priority in an active state is abort, completion, timeout, pause.
    always_comb begin
        state_next     = state_reg;
        saved_next     = saved_reg;
        timer_next     = timer_reg;
        target_next    = target_reg;
        deb_next       = '0;
        flow_err_next  = 1'b0;
        drain_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (drain_req) begin
                    if (SHORTCUT_EN && level_empty) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRAIN;
                        timer_next = '0;
                    end
                end else if (fill_req) begin
                    target_next = target_level;
                    if (SHORTCUT_EN && (water_level_sensor >= target_level)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_FILL;
                        timer_next = '0;
                    end
                end
            end
            ST_FILL: begin
                timer_next = timer_reg + 1'b1;
                deb_next   = level_full ? deb_reg + 1'b1 : '0;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (level_full && deb_met) begin
                    state_next = ST_DONE;
                end else if (timer_reg == TIMER_W'(FILL_TIMEOUT - 1)) begin
                    state_next    = ST_ERROR;
                    flow_err_next = 1'b1;
                end else if (pause) begin
                    state_next = ST_PAUSED;
                    saved_next = ST_FILL;
                end
            end
            ST_DRAIN: begin
                timer_next = timer_reg + 1'b1;
                deb_next   = level_empty ? deb_reg + 1'b1 : '0;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (level_empty && deb_met) begin
                    state_next = ST_DONE;
                end else if (timer_reg == TIMER_W'(DRAIN_TIMEOUT - 1)) begin
                    state_next     = ST_ERROR;
                    drain_err_next = 1'b1;
                end else if (pause) begin
                    state_next = ST_PAUSED;
                    saved_next = ST_DRAIN;
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!pause) begin
                    state_next = saved_reg;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                flow_err_next  = flow_err_reg;
                drain_err_next = drain_err_reg;
                if (clear_error) begin
                    state_next     = ST_IDLE;
                    flow_err_next  = 1'b0;
                    drain_err_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign water_valve      = valve_reg;
    assign drain_pump       = pump_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign water_flow_error = flow_err_reg;
    assign drainage_error   = drain_err_reg;

endmodule

// File: tb/tb_fill_drain_sequencer.sv
// Testbench for fill_drain_sequencer: directed scenarios followed by random
// stimulus, compared every cycle against an operation-level reference model.
module tb_fill_drain_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fill_req;
    logic       drain_req;
    logic [9:0] target_level;
    logic [9:0] water_level_sensor;
    logic       pause;
    logic       abort;
    logic       clear_error;
    logic       water_valve;
    logic       drain_pump;
    logic       busy;
    logic       done;
    logic       water_flow_error;
    logic       drainage_error;

    int n_vec  = 0;
    int n_fail = 0;
    int valve_cnt = 0;
    int pump_cnt  = 0;
    int done_cnt  = 0;

    // Reference model: which operation is active, whether it is held, and how
    // many active cycles it has consumed.
    int         m_op = 0;        // 0 none, 1 fill, 2 drain
    bit         m_held = 1'b0;
    int         m_elapsed = 0;
    logic [9:0] m_target = '0;
    bit         m_done = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_derr = 1'b0;

    fill_drain_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .fill_req          (fill_req),
        .drain_req         (drain_req),
        .target_level      (target_level),
        .water_level_sensor(water_level_sensor),
        .pause             (pause),
        .abort             (abort),
        .clear_error       (clear_error),
        .water_valve       (water_valve),
        .drain_pump        (drain_pump),
        .busy              (busy),
        .done              (done),
        .water_flow_error  (water_flow_error),
        .drainage_error    (drainage_error)
    );

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit reached;
        int limit;
        if (!reset) begin
            m_op = 0; m_held = 0; m_elapsed = 0; m_target = '0;
            m_done = 0; m_ferr = 0; m_derr = 0;
        end else if (m_ferr || m_derr) begin
            if (clear_error) begin
                m_ferr = 0;
                m_derr = 0;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (m_op == 0) begin
            if (drain_req) begin
                if (water_level_sensor <= 10'd20) m_done = 1;
                else begin m_op = 2; m_elapsed = 0; m_held = 0; end
            end else if (fill_req) begin
                m_target = target_level;
                if (water_level_sensor >= target_level) m_done = 1;
                else begin m_op = 1; m_elapsed = 0; m_held = 0; end
            end
        end else if (abort) begin
            m_op = 0; m_held = 0;
        end else if (m_held) begin
            if (!pause) m_held = 0;
        end else begin
            reached = (m_op == 1) ? (water_level_sensor >= m_target)
                                  : (water_level_sensor <= 10'd20);
            limit = (m_op == 1) ? 40 : 30;
            m_elapsed++;
            if (reached) begin
                m_op = 0; m_done = 1;
            end else if (m_elapsed == limit) begin
                if (m_op == 1) m_ferr = 1; else m_derr = 1;
                m_op = 0;
            end else if (pause) begin
                m_held = 1;
            end
        end
    endtask

    // One clock: model update at the edge, output comparison 1 ns later.
    task automatic tick(input string tag);
        logic [5:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        got = {water_valve, drain_pump, busy, done, water_flow_error, drainage_error};
        exp = {(m_op == 1) && !m_held, (m_op == 2) && !m_held, m_op != 0,
               m_done, m_ferr, m_derr};
        check(tag, 32'(got), 32'(exp));
        if (water_valve) valve_cnt++;
        if (drain_pump)  pump_cnt++;
        if (done)        done_cnt++;
    endtask

    task automatic idle_inputs();
        fill_req = 0; drain_req = 0; pause = 0; abort = 0; clear_error = 0;
    endtask

    initial begin
        logic [9:0] lv_tab [8];
        lv_tab[0] = 10'd0;   lv_tab[1] = 10'd20;  lv_tab[2] = 10'd21;  lv_tab[3] = 10'd100;
        lv_tab[4] = 10'd299; lv_tab[5] = 10'd300; lv_tab[6] = 10'd301; lv_tab[7] = 10'd1023;

        reset = 0; idle_inputs(); target_level = 0; water_level_sensor = 0;
        repeat (3) tick("reset");
        check("reset_outputs", 32'({water_valve, drain_pump, busy, done,
                                    water_flow_error, drainage_error}), 32'd0);
        reset = 1;
        tick("idle");

        // Normal fill: valve open 10 cycles, then a single done pulse.
        valve_cnt = 0; done_cnt = 0;
        fill_req = 1; target_level = 300; water_level_sensor = 0;
        tick("fill_start");
        fill_req = 0;
        repeat (9) tick("fill_run");
        water_level_sensor = 300;
        tick("fill_reach");
        tick("fill_done");
        tick("fill_idle");
        check("fill_valve_cycles", valve_cnt, 10);
        check("fill_done_pulses", done_cnt, 1);
        check("fill_busy_after", 32'(busy), 0);

        // Fill timeout: 40 valve cycles, sticky flow error, then clear.
        valve_cnt = 0;
        fill_req = 1; target_level = 300; water_level_sensor = 100;
        tick("fto_start");
        fill_req = 0;
        repeat (45) tick("fto_run");
        check("fto_valve_cycles", valve_cnt, 40);
        check("fto_flag", 32'(water_flow_error), 1);
        abort = 1; drain_req = 1;
        tick("fto_ignore");
        abort = 0; drain_req = 0; clear_error = 1;
        tick("fto_clear");
        clear_error = 0;
        check("fto_flag_cleared", 32'(water_flow_error), 0);

        // Drain with pause: pump off while held, done after resume.
        pump_cnt = 0; done_cnt = 0;
        drain_req = 1; water_level_sensor = 300;
        tick("dp_start");
        drain_req = 0;
        repeat (4) tick("dp_run");
        pause = 1;
        repeat (8) tick("dp_pause");
        check("dp_pump_paused", 32'(drain_pump), 0);
        pause = 0; water_level_sensor = 0;
        repeat (3) tick("dp_resume");
        check("dp_pump_cycles", pump_cnt, 6);
        check("dp_done_pulses", done_cnt, 1);

        // Drain timeout: pump on exactly 30 cycles.
        pump_cnt = 0;
        drain_req = 1; water_level_sensor = 300;
        tick("dto_start");
        drain_req = 0;
        repeat (34) tick("dto_run");
        check("dto_pump_cycles", pump_cnt, 30);
        check("dto_flag", 32'(drainage_error), 1);
        clear_error = 1;
        tick("dto_clear");
        clear_error = 0;

        // Priority: drain wins; abort beats pause; reset mid-fill.
        done_cnt = 0;
        fill_req = 1; drain_req = 1; target_level = 500; water_level_sensor = 300;
        tick("prio_start");
        fill_req = 0; drain_req = 0;
        check("prio_drain", 32'(drain_pump), 1);
        repeat (3) tick("prio_run");
        abort = 1; pause = 1;
        tick("prio_abort");
        abort = 0; pause = 0;
        check("prio_abort_idle", 32'(busy), 0);
        fill_req = 1;
        tick("rst_fill");
        fill_req = 0;
        repeat (2) tick("rst_run");
        reset = 0;
        tick("rst_mid");
        check("rst_mid_outputs", 32'({water_valve, drain_pump, busy, done,
                                      water_flow_error, drainage_error}), 32'd0);
        reset = 1;
        check("prio_no_done", done_cnt, 0);

        // Boundaries of the IDLE shortcuts.
        drain_req = 1; water_level_sensor = 20;  tick("b_drain20"); drain_req = 0; tick("b_idle");
        drain_req = 1; water_level_sensor = 21;  tick("b_drain21"); drain_req = 0; tick("b_run");
        abort = 1; tick("b_abort"); abort = 0;
        fill_req = 1; target_level = 700; water_level_sensor = 700; tick("b_fill_eq");
        fill_req = 0; tick("b_idle2");

        // Random traffic with slowly changing level.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            fill_req    = ($urandom_range(0, 9) == 0);
            drain_req   = ($urandom_range(0, 14) == 0);
            pause       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            clear_error = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                target_level = ($urandom_range(0, 1) == 0) ? 10'd300 : 10'($urandom);
            if ($urandom_range(0, 24) == 0)
                water_level_sensor = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                                                 : lv_tab[$urandom_range(0, 7)];
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fill_drain_sequencer.md
Name: fill_drain_sequencer

Overview:
- Sequences the water valve and drain pump on behalf of the main washing-machine FSM.
- The FSM issues one-shot fill or drain commands. This block drives the actuators, watches water_level_sensor, enforces timeouts and raises the water-flow and drainage error flags.
- Sits between the main FSM and the valve/pump outputs. It owns both actuators exclusively, so they are never on together.

Parameters:
- LEVEL_W, 10, width of the level sensor and target level.
- FILL_TIMEOUT, 40, max cycles spent in FILL (excluding PAUSED) before a flow error.
- DRAIN_TIMEOUT, 30, max cycles spent in DRAIN (excluding PAUSED) before a drainage error.
- EMPTY_LEVEL, 20, drum counts as empty when level <= EMPTY_LEVEL.
- DEBOUNCE, 3, consecutive cycles a level condition must hold (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- fill_req  input  1  request fill to target_level; sampled only in IDLE.
- drain_req  input  1  request drain to EMPTY_LEVEL; sampled only in IDLE.
- target_level  input  LEVEL_W  fill target; latched when fill_req is accepted.
- water_level_sensor  input  LEVEL_W  current water level.
- pause  input  1  level-sensitive hold.
- abort  input  1  cancel the active operation.
- clear_error  input  1  leave ERROR.
- water_valve  output  1  valve open.
- drain_pump  output  1  pump on.
- busy  output  1  high in FILL, DRAIN and PAUSED.
- done  output  1  one-cycle completion pulse.
- water_flow_error  output  1  sticky fill-timeout flag.
- drainage_error  output  1  sticky drain-timeout flag.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; all outputs 0; timer 0; latched target 0. Reset mid-operation shuts the valve/pump on the next edge and discards any saved state.
- All outputs are registered Moore outputs decoded from state. Each follows its state entry by zero cycles beyond the clocking edge.
- States: IDLE, FILL, DRAIN, PAUSED, DONE, ERROR.
- Outputs per state:
  - FILL: water_valve=1.
  - DRAIN: drain_pump=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - ERROR: exactly one of water_flow_error or drainage_error is 1, per the originating operation.
- IDLE accept rules:
  - drain_req=1 → DRAIN. Drain wins if fill_req is asserted in the same cycle.
  - Else fill_req=1 → latch target_level.
  - If water_level_sensor >= target_level in that same cycle → DONE directly; the valve never opens.
  - Otherwise → FILL.
  - A drain_req when level <= EMPTY_LEVEL → DONE directly.
  - Requests arriving outside IDLE are ignored; they are not queued.
- Timer:
  - Cleared on entry to FILL or DRAIN.
  - Increments once per cycle in FILL/DRAIN; frozen in PAUSED.
  - Width is clog2(max(FILL_TIMEOUT, DRAIN_TIMEOUT)) + 1.
- FILL exit:
  - Level >= latched target → DONE.
  - Else timer == FILL_TIMEOUT-1 → ERROR (flow).
  - Level reached has priority over timeout in the same cycle.
- DRAIN exit:
  - Level <= EMPTY_LEVEL → DONE.
  - Else timer == DRAIN_TIMEOUT-1 → ERROR (drainage).
- Pause:
  - pause=1 in FILL/DRAIN → PAUSED. The originating state is saved; valve and pump are off; busy stays 1.
  - pause=0 → return to the saved state with the timer value intact.
  - Level checks are not evaluated while PAUSED.
- Abort:
  - abort=1 in FILL, DRAIN or PAUSED → IDLE next cycle, actuators off, no done pulse.
  - Abort has priority over pause, completion and timeout.
  - Abort is ignored in IDLE, DONE and ERROR.
- ERROR:
  - Held until clear_error=1 → IDLE.
  - abort, fill_req and drain_req are ignored; both actuators stay off.
- Comparisons are unsigned at full LEVEL_W width; there is no wrap-around.

Optional Feature:
- Macro: LEVEL_DEBOUNCE_EN.
- Defined:
  - Completion conditions (level >= target in FILL, level <= EMPTY_LEVEL in DRAIN) must hold DEBOUNCE consecutive non-paused cycles before moving to DONE.
  - A debounce counter clears whenever the condition is false, on state entry, and in PAUSED.
  - Timeout is still checked every cycle and wins if it expires before debounce completes.
  - The IDLE direct-to-DONE shortcut is disabled; the block always enters FILL/DRAIN.
- Undefined: single-cycle comparison as described in Behaviour.

Test Plan:
- Normal fill:
  - Stimulus: fill_req with target_level=300, level=0; level raised to 300 after 10 cycles in FILL.
  - Response: water_valve high for 10 cycles; next cycle done=1 for one cycle; then IDLE with busy=0.
- Fill timeout:
  - Stimulus: fill_req with target_level=300; level held at 100.
  - Response: water_valve high for exactly 40 cycles; then water_flow_error=1, held.
  - Then clear_error=1 → IDLE with the flag cleared.
- Drain with pause:
  - Stimulus: drain_req at level=300; pause for 8 cycles after 5 cycles in DRAIN; level=0 after resume.
  - Response: drain_pump off during pause; timer frozen at 5; done pulse after resume.
- Drain timeout:
  - Stimulus: drain_req with level stuck at 300.
  - Response: drain_pump high for exactly 30 cycles; then drainage_error=1.
- Priority and abort:
  - Stimulus: fill_req=drain_req=1 in IDLE.
  - Response: DRAIN entered.
  - Then abort=1 together with pause=1 mid-DRAIN → IDLE next cycle, no done.
  - Then reset=0 mid-FILL → all outputs 0 next edge.
- Debounce (with LEVEL_DEBOUNCE_EN):
  - Stimulus: FILL with level toggling 300/0 each cycle, then steady at 300.
  - Response: done only after 3 steady cycles.
  - Also: fill_req with level already 300 enters FILL before DONE.
